// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the hardwired control sequencer: the FSM state
// encoding, the 5-bit opcode map, the IR field bit positions, the T1 memory
// wait rule and a helper that sorts an opcode into its execute-sequence class.
// No ports (package).
// ---------------------------------------------------------------------------
package ctrl_pkg;

  // Sequencer states: fetch is T0..T2, execute uses T3..T6 as needed.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  // Which register field of the IR drives the one-hot register decode.
  typedef enum logic [1:0] {
    SEL_RA = 2'd0,
    SEL_RB = 2'd1,
    SEL_RC = 2'd2
  } reg_field_t;

  // Execute-sequence families; every opcode maps onto exactly one of these.
  typedef enum logic [2:0] {
    CLS_RFMT    = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_UNARY   = 3'd2,
    CLS_MFHI    = 3'd3,
    CLS_MFLO    = 3'd4,
    CLS_NOP     = 3'd5,
    CLS_HALT    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

  // Opcode map.
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  // IR field positions.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // T1 is held for as long as mem_rdy sits at this level.
  localparam logic T1_WAIT_LEVEL = 1'b0;

  // Sort an opcode into its execute family. MUL/DIV fall back to illegal
  // when the multiply/divide sequence is not built in.
  function automatic instr_class_t classify(input logic [4:0] opcode,
                                            input logic       muldivEn);
    instr_class_t cls;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CLS_RFMT;
      OP_DIV, OP_MUL:                  cls = muldivEn ? CLS_MULDIV : CLS_ILLEGAL;
      OP_NEG, OP_NOT:                  cls = CLS_UNARY;
      OP_MFHI:                         cls = CLS_MFHI;
      OP_MFLO:                         cls = CLS_MFLO;
      OP_NOP:                          cls = CLS_NOP;
      OP_HALT:                         cls = CLS_HALT;
      default:                         cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// ---------------------------------------------------------------------------
// reg_sel_decode
// Picks one of the three IR register fields (Ra, Rb, Rc) and expands it into
// a 16-bit one-hot register strobe. Used once for the bus-drive vector and
// once for the register-load vector.
// Ports:
//   i_en     in   1  strobe enable; 0 forces an all-zero output
//   i_sel    in   2  field select (SEL_RA / SEL_RB / SEL_RC)
//   i_ra     in   4  Ra field
//   i_rb     in   4  Rb field
//   i_rc     in   4  Rc field
//   o_onehot out 16  one-hot register strobe, bit n selects Rn
// ---------------------------------------------------------------------------
module reg_sel_decode
  import ctrl_pkg::*;
(
  input  logic        i_en,
  input  reg_field_t  i_sel,
  input  logic [3:0]  i_ra,
  input  logic [3:0]  i_rb,
  input  logic [3:0]  i_rc,
  output logic [15:0] o_onehot
);

  logic [3:0] w_idx;

  // Field mux followed by a 4-to-16 decode; an unused select code
  // falls back to Ra so the decode is always fully specified.
  always_comb begin
    w_idx = i_ra;
    case (i_sel)
      SEL_RA:  w_idx = i_ra;
      SEL_RB:  w_idx = i_rb;
      SEL_RC:  w_idx = i_rc;
      default: w_idx = i_ra;
    endcase
    o_onehot = i_en ? (16'h0001 << w_idx) : 16'h0000;
  end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Hardwired Moore-style control unit for the CPU datapath. Runs the fetch
// sequence T0..T2, then the execute sequence for R-format ALU, MUL/DIV,
// NEG/NOT, MFHI/MFLO, NOP and HALT. All strobes are decoded from the state
// register and the IR; at most one bus source is active in any cycle.
// Build option: define CTRL_MULDIV_EN to enable the MUL/DIV sequence;
// otherwise opcodes 15/16 are illegal and MUL/DIV are tied to 0.
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous active-low reset (forces IDLE)
//   ir       in  32  instruction register contents
//   mem_rdy  in   1  memory data valid, only looked at in T1
//   R_out    out 16  one-hot register bus drive
//   R_in     out 16  one-hot register load
//   HIout, LOout, Zhighout, Zlowout, PCout, MDRout      bus source selects
//   HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin      register loads
//   Read, IncPC                                         memory read, PC inc
//   AND .. NOT                                          ALU operation selects
//   run      out  1  low only while halted
//   illegal  out  1  one-cycle pulse in T3 on an unsupported opcode
// ---------------------------------------------------------------------------
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic [15:0] R_out,
  output logic [15:0] R_in,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        IRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Read,
  output logic        IncPC,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        run,
  output logic        illegal
);

`ifdef CTRL_MULDIV_EN
  localparam logic MULDIV_EN = 1'b1;
`else
  localparam logic MULDIV_EN = 1'b0;
`endif

  state_t       r_state;
  state_t       w_nextState;
  logic [4:0]   w_opcode;
  instr_class_t w_class;
  logic         w_routEn;
  logic         w_rinEn;
  reg_field_t   w_routSel;
  reg_field_t   w_rinSel;
  logic         w_mulOp;
  logic         w_divOp;
  logic [14:0]  w_unusedIrBits;

  assign w_opcode       = ir[OPC_MSB:OPC_LSB];
  assign w_class        = classify(w_opcode, MULDIV_EN);
  assign w_unusedIrBits = ir[14:0];

  // State register. Reset drops straight to IDLE so every strobe clears
  // in the same cycle the reset arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Sequencing. The IR is only consulted from T3 onward, because it is
  // loaded at the end of T2. HALT is a sink left only through reset.
  always_comb begin
    w_nextState = ST_IDLE;
    case (r_state)
      ST_IDLE: w_nextState = ST_T0;
      ST_T0:   w_nextState = ST_T1;
      ST_T1:   w_nextState = (mem_rdy == T1_WAIT_LEVEL) ? ST_T1 : ST_T2;
      ST_T2:   w_nextState = ST_T3;
      ST_T3: begin
        case (w_class)
          CLS_RFMT, CLS_MULDIV, CLS_UNARY: w_nextState = ST_T4;
          CLS_HALT:                        w_nextState = ST_HALT;
          default:                         w_nextState = ST_T0;
        endcase
      end
      ST_T4: begin
        case (w_class)
          CLS_RFMT, CLS_MULDIV: w_nextState = ST_T5;
          default:              w_nextState = ST_T0;
        endcase
      end
      ST_T5:   w_nextState = (w_class == CLS_MULDIV) ? ST_T6 : ST_T0;
      ST_T6:   w_nextState = ST_T0;
      ST_HALT: w_nextState = ST_HALT;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Strobe decode. Everything defaults low with run high; each state only
  // raises what it needs. ALU op lines are raised only alongside Zin.
  always_comb begin
    w_routEn  = 1'b0;
    w_rinEn   = 1'b0;
    w_routSel = SEL_RA;
    w_rinSel  = SEL_RA;
    w_mulOp   = 1'b0;
    w_divOp   = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    PCout = 1'b0; MDRout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; PCin = 1'b0; IRin = 1'b0;
    Zin = 1'b0; Yin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    Read = 1'b0; IncPC = 1'b0;
    AND = 1'b0; OR = 1'b0; ADD = 1'b0; SUB = 1'b0;
    SHR = 1'b0; SHRA = 1'b0; SHL = 1'b0; ROR = 1'b0; ROL = 1'b0;
    NEG = 1'b0; NOT = 1'b0;
    run     = 1'b1;
    illegal = 1'b0;
    case (r_state)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
      end
      ST_T1: begin
        Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        case (w_class)
          CLS_RFMT: begin
            w_routEn = 1'b1; w_routSel = SEL_RB; Yin = 1'b1;
          end
          CLS_MULDIV: begin
            w_routEn = 1'b1; w_routSel = SEL_RA; Yin = 1'b1;
          end
          CLS_UNARY: begin
            w_routEn = 1'b1; w_routSel = SEL_RB; Zin = 1'b1;
            NEG = (w_opcode == OP_NEG);
            NOT = (w_opcode == OP_NOT);
          end
          CLS_MFHI: begin
            HIout = 1'b1; w_rinEn = 1'b1; w_rinSel = SEL_RA;
          end
          CLS_MFLO: begin
            LOout = 1'b1; w_rinEn = 1'b1; w_rinSel = SEL_RA;
          end
          CLS_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        case (w_class)
          CLS_RFMT: begin
            w_routEn = 1'b1; w_routSel = SEL_RC; Zin = 1'b1;
            case (w_opcode)
              OP_ADD:  ADD  = 1'b1;
              OP_SUB:  SUB  = 1'b1;
              OP_AND:  AND  = 1'b1;
              OP_OR:   OR   = 1'b1;
              OP_ROR:  ROR  = 1'b1;
              OP_ROL:  ROL  = 1'b1;
              OP_SHR:  SHR  = 1'b1;
              OP_SHRA: SHRA = 1'b1;
              OP_SHL:  SHL  = 1'b1;
              default: ;
            endcase
          end
          CLS_MULDIV: begin
            w_routEn = 1'b1; w_routSel = SEL_RB; Zin = 1'b1;
            w_mulOp = (w_opcode == OP_MUL);
            w_divOp = (w_opcode == OP_DIV);
          end
          CLS_UNARY: begin
            Zlowout = 1'b1; w_rinEn = 1'b1; w_rinSel = SEL_RA;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (w_class)
          CLS_RFMT: begin
            Zlowout = 1'b1; w_rinEn = 1'b1; w_rinSel = SEL_RA;
          end
          CLS_MULDIV: begin
            Zlowout = 1'b1; LOin = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        if (w_class == CLS_MULDIV) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end
      end
      ST_HALT: run = 1'b0;
      default: ;
    endcase
  end

  // Without the multiply/divide option these selects are hard zeros.
`ifdef CTRL_MULDIV_EN
  assign MUL = w_mulOp;
  assign DIV = w_divOp;
`else
  logic w_unusedMulDiv;
  assign w_unusedMulDiv = w_mulOp | w_divOp;
  assign MUL = 1'b0;
  assign DIV = 1'b0;
`endif

  // Bus-drive and load vectors share the same field-select decoder.
  reg_sel_decode u_routDecode (
    .i_en     (w_routEn),
    .i_sel    (w_routSel),
    .i_ra     (ir[RA_MSB:RA_LSB]),
    .i_rb     (ir[RB_MSB:RB_LSB]),
    .i_rc     (ir[RC_MSB:RC_LSB]),
    .o_onehot (R_out)
  );

  reg_sel_decode u_rinDecode (
    .i_en     (w_rinEn),
    .i_sel    (w_rinSel),
    .i_ra     (ir[RA_MSB:RA_LSB]),
    .i_rb     (ir[RB_MSB:RB_LSB]),
    .i_rc     (ir[RC_MSB:RC_LSB]),
    .o_onehot (R_in)
  );

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the CPU datapath's control inputs from the fetched instruction. It produces, cycle by cycle, the same Rout/Rin, bus-source, register-load, Read/IncPC and ALU-operation strobes that the datapath consumes. It runs the fetch sequence T0–T2 and then the execute sequence for register-format ALU, MUL/DIV, NEG/NOT, MFHI/MFLO, NOP and HALT instructions. It sits between the IR/memory and the `datapath` instance inside the CPU top level.

## Interface
- No parameters; field positions and opcodes are package constants.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces the IDLE state immediately.
- `ir`  in  32  current IR contents: opcode `ir[31:27]`, Ra `ir[26:23]`, Rb `ir[22:19]`, Rc `ir[18:15]`.
- `mem_rdy`  in  1  memory data valid; sampled only in T1.
- `R_out`  out  16  one-hot register bus drive, bit n is RnOut.
- `R_in`  out  16  one-hot register load, bit n is RnIn.
- `HIout, LOout, Zhighout, Zlowout, PCout, MDRout`  out  1 each  bus source selects.
- `HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin`  out  1 each  register loads.
- `Read, IncPC`  out  1 each  memory read and PC increment.
- `AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT`  out  1 each  ALU operation select.
- `run`  out  1  1 unless halted.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- Moore machine. Outputs are decoded combinationally from the state register and `ir`; at most one bus source is active per cycle.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. In IDLE all outputs are 0 and `run`=1; next state is T0.
- Fetch:
  - T0: PCout, MARin, IncPC, PCin.
  - T1: Read, MDRin. Hold T1 while `mem_rdy`=0.
  - T2: MDRout, IRin.
- R-format, opcodes 3 add, 4 sub, 5 and, 6 or, 7 ror, 8 rol, 9 shr, 10 shra, 11 shl:
  - T3: R_out[Rb], Yin.
  - T4: R_out[Rc], op line, Zin.
  - T5: Zlowout, R_in[Ra]. Next state T0.
- MUL (16) / DIV (15):
  - T3: R_out[Ra], Yin.
  - T4: R_out[Rb], MUL or DIV, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Next state T0.
- NEG (17) / NOT (18):
  - T3: R_out[Rb], op line, Zin.
  - T4: Zlowout, R_in[Ra]. Next state T0.
- MFHI (24): T3 HIout, R_in[Ra]. MFLO (25): T3 LOout, R_in[Ra]. Both then go to T0.
- NOP (26): T3 with no outputs, then T0.
- HALT (27): T3 goes to HALT. In HALT all outputs are 0 and `run`=0; HALT exits only on reset.
- Any other opcode: `illegal`=1 in T3, no other outputs, next state T0.
- An op line is asserted only in the cycle that asserts Zin.

## Timing
- Reset value of every output is 0, except `run`=1. Reset is asynchronous, so assertion mid-sequence clears all strobes within the same cycle. After deassertion: IDLE for one cycle, then T0.
- Instruction length from T0 to the next T0, with `mem_rdy`=1:
  - R-format: 6 cycles.
  - MUL/DIV: 7 cycles.
  - NEG/NOT: 5 cycles.
  - MFHI/MFLO/NOP/illegal: 4 cycles.
- Each extra cycle of `mem_rdy`=0 in T1 adds one cycle; Read and MDRin stay high throughout.
- `ir` is sampled from T3 onward. IR is loaded at the end of T2, so the decode sees the new instruction in T3.
- Ra = Rb = Rc is legal: the same one-hot bit is used in both R_out and R_in, in different cycles.

## Configuration
- `CTRL_MULDIV_EN` defined: opcodes 15 and 16 run the T3–T6 sequence.
- Macro undefined: opcodes 15 and 16 are treated as illegal, and the MUL and DIV outputs are tied to 0.

## Structure
- Package `ctrl_pkg`:
  - state enum;
  - 5-bit opcode constants;
  - IR field bit positions;
  - the T1 wait rule as a named constant.
- Sub-module `reg_sel_decode`: selects the Ra, Rb or Rc field and performs the 4-to-16 one-hot decode for R_out and R_in.

## Test plan
- Reset low then high, `mem_rdy`=1 → IDLE, then T0 asserts PCout, MARin, IncPC, PCin; T2 asserts MDRout, IRin; all outputs are 0 while reset is low.
- `ir`=0x81300000 (mul R2,R6) → T3 R_out=0x0004 with Yin; T4 R_out=0x0040 with MUL and Zin; T5 Zlowout with LOin; T6 Zhighout with HIin; T0 follows 7 cycles after the previous T0.
- `ir`=0x18918000 (add R1,R2,R3) → T3 R_out=0x0004 with Yin; T4 R_out=0x0008 with ADD and Zin; T5 Zlowout with R_in=0x0002.
- `mem_rdy` held 0 for 3 cycles in T1 → Read and MDRin high for 4 cycles; IRin only in the following cycle.
- `ir`=0xD8000000 (halt) → `run`=0 and all outputs 0 indefinitely; reset returns to IDLE with `run`=1.
- `ir`=0xF8000000 → `illegal`=1 for exactly one cycle, then T0. With `CTRL_MULDIV_EN` undefined, `ir`=0x81300000 produces the same response.
